// File: rtl/alu_multibyte_sequencer_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: carry-select codes,
// FSM state encoding and the operand-length field width.
// Latency: n/a (definitions only). Backpressure: n/a.
package alu_multibyte_sequencer_pkg;

  // Operand length field: value is byte count minus one (0..3 -> 1..4 bytes).
  localparam int OPLEN_W = 2;

  // Carry-select codes presented to the ALU as {CS1,CS0}. 2'b11 is never driven.
  localparam logic [1:0] CS_ZERO = 2'b00;
  localparam logic [1:0] CS_PREV = 2'b01;
  localparam logic [1:0] CS_ONE  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/alu_flag_accumulator.sv
// Collects ALU flags over the result cycles of one multi-byte operation.
// Latency: result flags register at the end of the final result cycle.
// Backpressure: none; follows the sequencer's valid/last strobes every cycle.
// Ports: op_start clears the zero accumulator; res_vld marks a result byte on
// the bus; res_last marks the final result byte; Res* are the held outputs.
module alu_flag_accumulator (
  input  logic AluClock,
  input  logic Reset,
  input  logic op_start,
  input  logic res_vld,
  input  logic res_last,
  input  logic flag_overflow,
  input  logic flag_sign,
  input  logic flag_zero,
  input  logic flag_carry,
  output logic ResOverflow,
  output logic ResSign,
  output logic ResZero,
  output logic ResCarry
);

  // Running AND of the zero flag over every result byte seen so far.
  logic zero_acc;

  always_ff @(posedge AluClock) begin
    if (Reset) begin
      zero_acc    <= 1'b1;
      ResOverflow <= 1'b0;
      ResSign     <= 1'b0;
      ResZero     <= 1'b0;
      ResCarry    <= 1'b0;
    end else begin
      if (op_start) begin
        zero_acc <= 1'b1;
      end else if (res_vld) begin
        zero_acc <= zero_acc & flag_zero;
      end
      // Final byte's flags are folded in directly, so the accumulator never
      // needs an extra cycle after the last result.
      if (res_last) begin
        ResZero     <= zero_acc & flag_zero;
        ResCarry    <= flag_carry;
        ResSign     <= flag_sign;
        ResOverflow <= flag_overflow;
      end
    end
  end

endmodule

// File: rtl/alu_multibyte_sequencer.sv
// Sequences a 1..4 byte add through a byte-wide ALU: issue, write back, flags.
// Latency: Done pulses L+2 cycles after Start is sampled (L = OpLen+1).
// Backpressure: Start is accepted only while idle (Busy=0); otherwise ignored.
// Ports: Start/OpLen/FirstCarry request an operation; AluFlag* come from the
// ALU; AC7_CS1/AC6_CS0 select the adder carry-in; IssueIndex/WbIndex/Alu_Assert
// steer operand and result bytes; Busy/Done/Res* report progress and flags.
module alu_multibyte_sequencer
  import alu_multibyte_sequencer_pkg::*;
(
  input  logic               AluClock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [OPLEN_W-1:0] OpLen,
  input  logic               FirstCarry,
  input  logic               AluFlagOverflow,
  input  logic               AluFlagSign,
  input  logic               AluFlagZero,
  input  logic               AluFlagCarry,
  output logic               AC6_CS0,
  output logic               AC7_CS1,
  output logic [OPLEN_W-1:0] IssueIndex,
  output logic [OPLEN_W-1:0] WbIndex,
  output logic               Alu_Assert,
  output logic               Busy,
  output logic               Done,
  output logic               ResOverflow,
  output logic               ResSign,
  output logic               ResZero,
  output logic               ResCarry
);

  state_t             state, state_nxt;
  logic [OPLEN_W-1:0] cnt, cnt_nxt;
  logic [OPLEN_W-1:0] oplen_q;
  logic               first_carry_q;
  logic               wb_vld_q;
  logic [OPLEN_W-1:0] wb_idx_q;
  logic               done_q;
  logic [1:0]         cs;
  logic               accept;

  assign accept = (state == ST_IDLE) && Start;

  always_ff @(posedge AluClock) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Operation parameters are frozen at accept so mid-op input changes are inert.
  always_ff @(posedge AluClock) begin
    if (Reset) begin
      oplen_q       <= '0;
      first_carry_q <= 1'b0;
    end else if (accept) begin
      oplen_q       <= OpLen;
      first_carry_q <= FirstCarry;
    end
  end

  // Result phase trails issue by one cycle: the ALU registers its output.
  // The last ISSUE is always followed by DRAIN, so the final result lands in
  // DRAIN and Done follows it.
  always_ff @(posedge AluClock) begin
    if (Reset) begin
      wb_vld_q <= 1'b0;
      wb_idx_q <= '0;
      done_q   <= 1'b0;
    end else begin
      wb_vld_q <= (state == ST_ISSUE);
      wb_idx_q <= (state == ST_ISSUE) ? cnt : '0;
      done_q   <= (state == ST_DRAIN);
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cs         = CS_ZERO;
    IssueIndex = '0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          state_nxt = ST_ISSUE;
          cnt_nxt   = '0;
        end
      end
      ST_ISSUE: begin
        IssueIndex = cnt;
        if (cnt == '0) begin
          cs = first_carry_q ? CS_ONE : CS_ZERO;
        end else begin
          cs = CS_PREV;
        end
        if (cnt == oplen_q) begin
          state_nxt = ST_DRAIN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_DRAIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign AC6_CS0    = cs[0];
  assign AC7_CS1    = cs[1];
  assign WbIndex    = wb_idx_q;
  assign Alu_Assert = ~wb_vld_q;
  assign Busy       = (state != ST_IDLE);
  assign Done       = done_q;

  alu_flag_accumulator u_flag_acc (
    .AluClock      (AluClock),
    .Reset         (Reset),
    .op_start      (accept),
    .res_vld       (wb_vld_q),
    .res_last      (state == ST_DRAIN),
    .flag_overflow (AluFlagOverflow),
    .flag_sign     (AluFlagSign),
    .flag_zero     (AluFlagZero),
    .flag_carry    (AluFlagCarry),
    .ResOverflow   (ResOverflow),
    .ResSign       (ResSign),
    .ResZero       (ResZero),
    .ResCarry      (ResCarry)
  );

endmodule

// File: tb/tb_alu_multibyte_sequencer.sv
// Self-checking bench for alu_multibyte_sequencer with a byte-wide ALU model.
// Expected results come from whole-word arithmetic on the operands.
// Inputs are driven after the rising edge; outputs are sampled on the falling edge.
module tb_alu_multibyte_sequencer;

  logic       AluClock;
  logic       Reset;
  logic       Start;
  logic [1:0] OpLen;
  logic       FirstCarry;
  logic       AluFlagOverflow;
  logic       AluFlagSign;
  logic       AluFlagZero;
  logic       AluFlagCarry;
  logic       AC6_CS0;
  logic       AC7_CS1;
  logic [1:0] IssueIndex;
  logic [1:0] WbIndex;
  logic       Alu_Assert;
  logic       Busy;
  logic       Done;
  logic       ResOverflow;
  logic       ResSign;
  logic       ResZero;
  logic       ResCarry;

  int checks = 0;
  int errors = 0;

  // Operands the ALU model reads, and the flags expected to be held on Res*.
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  res_prev; // {overflow, sign, zero, carry}

  alu_multibyte_sequencer dut (
    .AluClock        (AluClock),
    .Reset           (Reset),
    .Start           (Start),
    .OpLen           (OpLen),
    .FirstCarry      (FirstCarry),
    .AluFlagOverflow (AluFlagOverflow),
    .AluFlagSign     (AluFlagSign),
    .AluFlagZero     (AluFlagZero),
    .AluFlagCarry    (AluFlagCarry),
    .AC6_CS0         (AC6_CS0),
    .AC7_CS1         (AC7_CS1),
    .IssueIndex      (IssueIndex),
    .WbIndex         (WbIndex),
    .Alu_Assert      (Alu_Assert),
    .Busy            (Busy),
    .Done            (Done),
    .ResOverflow     (ResOverflow),
    .ResSign         (ResSign),
    .ResZero         (ResZero),
    .ResCarry        (ResCarry)
  );

  initial AluClock = 1'b0;
  always #5 AluClock = ~AluClock;

  // Byte ALU model: adds the operand bytes selected by IssueIndex with the
  // carry-in chosen by the carry-select lines, and presents the flags of that
  // sum one cycle later (registered output). Its carry register feeds CS=01.
  logic       alu_c;
  int         env_idx;
  logic [1:0] env_cs;
  logic [7:0] env_ab;
  logic [7:0] env_bb;
  logic       env_cin;
  logic [8:0] env_sum;

  initial begin
    AluFlagOverflow = 1'b0;
    AluFlagSign     = 1'b0;
    AluFlagZero     = 1'b0;
    AluFlagCarry    = 1'b0;
    alu_c           = 1'b0;
    forever begin
      @(negedge AluClock);
      env_idx = int'(IssueIndex);
      env_cs  = {AC7_CS1, AC6_CS0};
      env_ab  = op_a[env_idx*8 +: 8];
      env_bb  = op_b[env_idx*8 +: 8];
      env_cin = (env_cs == 2'b10) ? 1'b1 : ((env_cs == 2'b01) ? alu_c : 1'b0);
      env_sum = {1'b0, env_ab} + {1'b0, env_bb} + {8'd0, env_cin};
      @(posedge AluClock);
      #1;
      alu_c           = env_sum[8];
      AluFlagZero     = (env_sum[7:0] == 8'd0);
      AluFlagCarry    = env_sum[8];
      AluFlagSign     = env_sum[7];
      AluFlagOverflow = (env_ab[7] == env_bb[7]) && (env_sum[7] != env_ab[7]);
    end
  end

  // Starts one operation in the current cycle and checks every cycle through
  // Done. Ends on the falling edge of the Done cycle with Start=0, so a caller
  // may immediately start another op in that same Done cycle.
  // spur_k in 1..L+1 raises Start in cycle t0+spur_k, which must be ignored.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] ol, input logic fc, input int spur_k);
    int          len;
    logic [63:0] mask;
    logic [63:0] sum;
    logic [3:0]  nres;
    logic [13:0] obs;
    logic [13:0] exp_v;
    logic [1:0]  e_cs;
    logic [1:0]  e_ii;
    logic [1:0]  e_wb;
    logic        e_aa;
    logic        e_busy;
    logic        e_done;
    logic [3:0]  e_res;
    len  = int'(ol) + 1;
    mask = (64'd1 << (8 * len)) - 64'd1;
    sum  = ({32'd0, a} & mask) + ({32'd0, b} & mask) + {63'd0, fc};
    nres = {(a[8*len-1] == b[8*len-1]) && (sum[8*len-1] != a[8*len-1]),
            sum[8*len-1], (sum & mask) == 64'd0, sum[8*len]};
    op_a       = a;
    op_b       = b;
    Start      = 1'b1;
    OpLen      = ol;
    FirstCarry = fc;
    for (int k = 1; k <= len + 2; k++) begin
      @(posedge AluClock);
      #1;
      Start      = (k == spur_k);
      OpLen      = 2'($urandom);
      FirstCarry = 1'($urandom);
      @(negedge AluClock);
      if (k == 1)        e_cs = fc ? 2'b10 : 2'b00;
      else if (k <= len) e_cs = 2'b01;
      else               e_cs = 2'b00;
      e_ii   = (k <= len) ? 2'(k - 1) : 2'd0;
      e_aa   = !(k >= 2 && k <= len + 1);
      e_wb   = (k >= 2 && k <= len + 1) ? 2'(k - 2) : 2'd0;
      e_busy = (k <= len + 1);
      e_done = (k == len + 2);
      e_res  = (k == len + 2) ? nres : res_prev;
      exp_v  = {e_cs, e_ii, e_wb, e_aa, e_busy, e_done, e_res};
      obs    = {AC7_CS1, AC6_CS0, IssueIndex, WbIndex, Alu_Assert, Busy, Done,
                ResOverflow, ResSign, ResZero, ResCarry};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s t0+%0d {cs,iss,wb,assert_n,busy,done,ovf,sgn,zro,cry}: got %b want %b",
                 name, k, obs, exp_v);
      end
    end
    res_prev = nres;
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    Reset = 1'b1;
    Start = 1'b1;
    OpLen = 2'd3;
    FirstCarry = 1'b1;
    op_a = '0;
    op_b = '0;
    @(posedge AluClock);
    #1;
    @(posedge AluClock);
    #1;
    @(negedge AluClock);
    obs = {AC7_CS1, AC6_CS0, IssueIndex, WbIndex, Alu_Assert, Busy, Done,
           ResOverflow, ResSign, ResZero, ResCarry};
    checks++;
    if (obs !== 14'b00_00_00_1_0_0_0000) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", obs, 14'b00_00_00_1_0_0_0000);
    end
    Reset = 1'b0;
    Start = 1'b0;
    @(posedge AluClock);
    #1;
    @(negedge AluClock);
    obs = {AC7_CS1, AC6_CS0, IssueIndex, WbIndex, Alu_Assert, Busy, Done,
           ResOverflow, ResSign, ResZero, ResCarry};
    checks++;
    if (obs !== 14'b00_00_00_1_0_0_0000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want %b", obs, 14'b00_00_00_1_0_0_0000);
    end
    res_prev = 4'b0000;
  endtask

  task automatic test_one_byte();
    run_op("one_byte", 32'h0000_007F, 32'h0000_0001, 2'd0, 1'b0, 0);
    checks++;
    if ({ResOverflow, ResSign, ResZero, ResCarry} !== 4'b1100) begin
      errors++;
      $display("FAIL one_byte_flags: got %b want 1100", {ResOverflow, ResSign, ResZero, ResCarry});
    end
  endtask

  task automatic test_two_byte();
    run_op("two_byte", 32'h0000_00FF, 32'h0000_0001, 2'd1, 1'b0, 0);
    checks++;
    if ({ResOverflow, ResSign, ResZero, ResCarry} !== 4'b0000) begin
      errors++;
      $display("FAIL two_byte_flags: got %b want 0000", {ResOverflow, ResSign, ResZero, ResCarry});
    end
    @(posedge AluClock);
    #1;
    @(negedge AluClock);
    checks++;
    if ({Done, Busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_single_pulse: got done,busy=%b want 00", {Done, Busy});
    end
  endtask

  task automatic test_four_byte();
    run_op("four_byte", 32'hFFFF_FFFF, 32'h0000_0001, 2'd3, 1'b0, 0);
    checks++;
    if ({ResOverflow, ResSign, ResZero, ResCarry} !== 4'b0011) begin
      errors++;
      $display("FAIL four_byte_flags: got %b want 0011", {ResOverflow, ResSign, ResZero, ResCarry});
    end
  endtask

  task automatic test_subtract();
    @(posedge AluClock);
    #1;
    run_op("subtract", 32'h0000_1234, 32'h0000_EDCB, 2'd1, 1'b1, 0);
    checks++;
    if ({ResOverflow, ResZero, ResCarry} !== 3'b011) begin
      errors++;
      $display("FAIL subtract_flags ovf,zro,cry: got %b want 011", {ResOverflow, ResZero, ResCarry});
    end
  endtask

  task automatic test_back_to_back();
    @(posedge AluClock);
    #1;
    // Spurious Start at t0+2 is ignored; the second op starts in the Done cycle.
    run_op("busy_start", 32'h89AB_CDEF, 32'h7654_3210, 2'd3, 1'b0, 2);
    run_op("back_to_back", 32'h0000_8000, 32'h0000_8000, 2'd1, 1'b0, 0);
    run_op("back_to_back2", 32'h0000_0000, 32'h0000_0000, 2'd2, 1'b0, 3);
  endtask

  task automatic test_reset_mid_op();
    logic [13:0] obs;
    @(posedge AluClock);
    #1;
    op_a = 32'h1111_1111;
    op_b = 32'h2222_2222;
    Start = 1'b1;
    OpLen = 2'd3;
    FirstCarry = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge AluClock);
      #1;
      Start = (k == 3);
      Reset = (k == 3);
      @(negedge AluClock);
      checks++;
      if (Busy !== 1'b1) begin
        errors++;
        $display("FAIL mid_op_busy t0+%0d: got %b want 1", k, Busy);
      end
    end
    @(posedge AluClock);
    #1;
    Reset = 1'b0;
    Start = 1'b0;
    @(negedge AluClock);
    obs = {AC7_CS1, AC6_CS0, IssueIndex, WbIndex, Alu_Assert, Busy, Done,
           ResOverflow, ResSign, ResZero, ResCarry};
    checks++;
    if (obs !== 14'b00_00_00_1_0_0_0000) begin
      errors++;
      $display("FAIL reset_abort: got %b want %b", obs, 14'b00_00_00_1_0_0_0000);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge AluClock);
      #1;
      @(negedge AluClock);
      checks++;
      if ({Done, Busy, Alu_Assert} !== 3'b001) begin
        errors++;
        $display("FAIL abort_no_done cycle %0d: got done,busy,assert_n=%b want 001", k,
                 {Done, Busy, Alu_Assert});
      end
    end
    res_prev = 4'b0000;
  endtask

  task automatic test_random();
    logic [1:0] ol;
    int         gap;
    for (int n = 0; n < 30; n++) begin
      ol  = 2'($urandom_range(0, 3));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge AluClock);
        #1;
        @(negedge AluClock);
        checks++;
        if ({Done, Busy} !== 2'b00) begin
          errors++;
          $display("FAIL random_gap op %0d: got done,busy=%b want 00", n, {Done, Busy});
        end
      end
      run_op("random", $urandom, $urandom, ol, 1'($urandom),
             $urandom_range(0, int'(ol) + 2));
    end
  endtask

  initial begin
    Reset      = 1'b1;
    Start      = 1'b0;
    OpLen      = 2'd0;
    FirstCarry = 1'b0;
    op_a       = '0;
    op_b       = '0;
    res_prev   = 4'b0000;
    test_reset();
    test_one_byte();
    test_two_byte();
    test_four_byte();
    test_subtract();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
